// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default baud timing.
// Used by both the receiver and the console transmitter so both ends agree on bit time.
package uart_pkg;

  localparam int CYCLES_DEFAULT = 10416;  // 100 MHz / 9600 baud
  localparam int CNT_W_DEFAULT  = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; RST_VAL sets the reset level.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing; a bad parity bit is reported as frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CYCLES = CYCLES_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_s;
  logic             rx_q;
  logic             stop_good;

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_good = rx_s && !par_err;
`else
  assign stop_good = rx_s;
`endif

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_q      <= 1'b1;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_q      <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A load in S_STOP below overrides this, giving accept-and-reload with no bubble.
      if (valid && ready) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          timer <= '0;
          if (rx_q && !rx_s) state <= S_START;
        end
        S_START: begin
          if (timer == HALF_TC) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == BIT_TC) begin
            timer          <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (timer == BIT_TC) begin
            timer   <= '0;
            par_err <= ^shreg ^ rx_s;
            state   <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Leave mid stop bit so a back-to-back start edge is never missed.
          if (timer == BIT_TC) begin
            timer <= '0;
            state <= S_IDLE;
            if (stop_good) begin
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit; received bytes checked against a queue.
// Define UART_RX_PARITY_EN to also exercise the 8E1 parity path.
module tb_uart_rx;

  localparam int CYC = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  int vectors = 0;
  int errors  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int rx_cnt  = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
  logic par_bit = 1'b0;
`endif

  uart_rx #(.CYCLES(CYC), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every new valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      rx_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          errors++;
          $error("FAIL unexpected_valid: observed data %0h expected no byte", data);
        end
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        assert (data === e) else begin
          errors++;
          $error("FAIL rx_data: observed %0h expected %0h", data, e);
        end
      end
    end
    prev_valid = valid;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_b);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fe0, ov0, rc0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    idle(10);

    // 1: single byte, consumer always ready
    ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h57;
`endif
    exp_q.push_back(8'h57);
    send_frame(8'h57, 1'b1);
    idle(20);
    check("t1_rx_count", rx_cnt, 1);
    check("t1_valid_dropped", valid, 1'b0);
    check("t1_no_errors", fe_cnt + ov_cnt, 0);

    // 2: back-to-back with consumer stalled -> overrun on second byte
    ready = 1'b0;
    exp_q.push_back(8'h0A);
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h0A;
`endif
    send_frame(8'h0A, 1'b1);
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h0D;
`endif
    send_frame(8'h0D, 1'b1);
    idle(10);
    check("t2_data_held", data, 8'h0A);
    check("t2_valid_held", valid, 1'b1);
    check("t2_overrun_pulses", ov_cnt, 1);
    check("t2_no_frame_err", fe_cnt, 0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_valid_after_accept", valid, 1'b0);
    check("t2_rx_count", rx_cnt, 2);

    // 3: short low glitch is rejected as a false start
    idle(10);
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(60);
    check("t3_rx_count", rx_cnt, 2);
    check("t3_no_frame_err", fe_cnt, 0);
    check("t3_valid", valid, 1'b0);

    // 4: bad stop bit then break; next frame still received
    fe0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'hA5;
`endif
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t4_frame_err_pulses", fe_cnt - fe0, 1);
    check("t4_no_valid", valid, 1'b0);
    check("t4_rx_count", rx_cnt, 2);
    idle(20);
    exp_q.push_back(8'h3C);
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h3C;
`endif
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("t4_rx_count_after", rx_cnt, 3);
    check("t4_frame_err_total", fe_cnt - fe0, 1);

    // 5: reset during data bit 3 discards the partial byte
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (CYC / 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_reset_data", data, 8'h00);
    check("t5_reset_valid", valid, 1'b0);
    check("t5_reset_frame_err", frame_err, 1'b0);
    check("t5_reset_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    idle(40);
    rc0 = rx_cnt;
    exp_q.push_back(8'h81);
`ifdef UART_RX_PARITY_EN
    par_bit = ^8'h81;
`endif
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t5_rx_count", rx_cnt - rc0, 1);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    fe0 = fe_cnt;
    rc0 = rx_cnt;
    par_bit = 1'b1;
    exp_q.push_back(8'h57);
    send_frame(8'h57, 1'b1);
    idle(20);
    check("t6_good_parity_rx", rx_cnt - rc0, 1);
    check("t6_good_parity_no_fe", fe_cnt - fe0, 0);
    par_bit = 1'b0;
    send_frame(8'h57, 1'b1);
    idle(20);
    check("t6_bad_parity_fe", fe_cnt - fe0, 1);
    check("t6_bad_parity_no_rx", rx_cnt - rc0, 1);
`endif

    ov0 = ov_cnt;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_overrun_total", ov0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
